// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point adder arbiter and its benches.
package fp_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_SEND_A = 3'd2,
    ST_SEND_B = 3'd3,
    ST_WAIT_Z = 3'd4,
    ST_RETURN = 3'd5
  } state_t;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN = 32'hFFC0_0000;

endpackage

// File: rtl/fp_adder_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [ID_W-1:0]  idx_o,
  output logic             vld_o
);

  int unsigned j;

  // Walk from the farthest candidate back to the pointer so the nearest one wins.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    j     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % N_REQ;
      if (req_i[j]) begin
        idx_o = ID_W'(j);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_adder_arbiter.sv
// Round-robin arbiter sharing one stb/ack floating-point adder among N_REQ requesters,
// with a single operation in flight.
module fp_adder_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  input  logic [N_REQ-1:0]        req_stb,
  output logic [N_REQ-1:0]        req_ack,
  output logic [DATA_W-1:0]       resp_z,
  output logic [N_REQ-1:0]        resp_stb,
  input  logic [N_REQ-1:0]        resp_ack,
  output logic [DATA_W-1:0]       add_a,
  output logic                    add_a_stb,
  input  logic                    add_a_ack,
  output logic [DATA_W-1:0]       add_b,
  output logic                    add_b_stb,
  input  logic                    add_b_ack,
  input  logic [DATA_W-1:0]       add_z,
  input  logic                    add_z_stb,
  output logic                    add_z_ack,
  output logic                    busy,
  output logic [ID_W-1:0]         grant_id
);

  import fp_pkg::*;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   req_ack_q, req_ack_d;
  logic [N_REQ-1:0]   resp_stb_q, resp_stb_d;
  logic               add_a_stb_q, add_a_stb_d;
  logic               add_b_stb_q, add_b_stb_d;
  logic               add_z_ack_q, add_z_ack_d;
  logic               busy_q, busy_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]  resp_z_q, resp_z_d;
  logic [DATA_W-1:0]  add_a_q, add_a_d;
  logic [DATA_W-1:0]  add_b_q, add_b_d;
  logic [DATA_W-1:0]  op_b_q, op_b_d;

  logic [ID_W-1:0]    pick_idx;
  logic               pick_vld;
  logic [N_REQ-1:0]   grant_mask;
  logic [DATA_W-1:0]  sel_a, sel_b;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req_i (req_stb),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  assign grant_mask = N_REQ'(1) << grant_q;
  assign sel_a      = req_a[grant_q*DATA_W +: DATA_W];
  assign sel_b      = req_b[grant_q*DATA_W +: DATA_W];

  always_comb begin
    state_d     = state_q;
    req_ack_d   = req_ack_q;
    resp_stb_d  = resp_stb_q;
    add_a_stb_d = add_a_stb_q;
    add_b_stb_d = add_b_stb_q;
    add_z_ack_d = add_z_ack_q;
    busy_d      = busy_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    resp_z_d    = resp_z_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    op_b_d      = op_b_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d   = pick_idx;
          req_ack_d = N_REQ'(1) << pick_idx;
          busy_d    = 1'b1;
          state_d   = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (req_stb[grant_q] && req_ack_q[grant_q]) begin
          req_ack_d   = '0;
          add_a_d     = sel_a;
          op_b_d      = sel_b;
          add_a_stb_d = 1'b1;
          state_d     = ST_SEND_A;
        end else if (!req_stb[grant_q]) begin
          // Requester withdrew before the transfer: abandon without moving the pointer.
          req_ack_d = '0;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_SEND_A: begin
        if (add_a_stb_q && add_a_ack) begin
          add_a_stb_d = 1'b0;
          add_b_d     = op_b_q;
          add_b_stb_d = 1'b1;
          state_d     = ST_SEND_B;
        end
      end
      ST_SEND_B: begin
        if (add_b_stb_q && add_b_ack) begin
          add_b_stb_d = 1'b0;
          add_z_ack_d = 1'b1;
          state_d     = ST_WAIT_Z;
        end
      end
      ST_WAIT_Z: begin
        if (add_z_stb && add_z_ack_q) begin
          resp_z_d    = add_z;
          add_z_ack_d = 1'b0;
          resp_stb_d  = grant_mask;
          state_d     = ST_RETURN;
        end
      end
      ST_RETURN: begin
        if (resp_stb_q[grant_q] && resp_ack[grant_q]) begin
          resp_stb_d = '0;
          rr_ptr_d   = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_ack_q   <= '0;
      resp_stb_q  <= '0;
      add_a_stb_q <= 1'b0;
      add_b_stb_q <= 1'b0;
      add_z_ack_q <= 1'b0;
      busy_q      <= 1'b0;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      resp_z_q    <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      op_b_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_ack_q   <= req_ack_d;
      resp_stb_q  <= resp_stb_d;
      add_a_stb_q <= add_a_stb_d;
      add_b_stb_q <= add_b_stb_d;
      add_z_ack_q <= add_z_ack_d;
      busy_q      <= busy_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      resp_z_q    <= resp_z_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      op_b_q      <= op_b_d;
    end
  end

  assign req_ack   = req_ack_q;
  assign resp_stb  = resp_stb_q;
  assign resp_z    = resp_z_q;
  assign add_a     = add_a_q;
  assign add_a_stb = add_a_stb_q;
  assign add_b     = add_b_q;
  assign add_b_stb = add_b_stb_q;
  assign add_z_ack = add_z_ack_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;

endmodule
